dff_meta: RTL and testbench

Metastability-hardening synchronizer that brings asynchronous inputs (reset buttons, extension-header pins, cross-domain status flags) into a single clock domain. It is a parameterized multi-stage flop chain with an optional per-bit stability filter and registered edge pulses. It sits between the pad-level I/O and the top-level reset/control state machines. The first four ports keep a fixed order so the block can be instantiated positionally as `(reset, d, clk, q)`.

---
 rtl/dff_meta_pkg.sv | 9 +
 rtl/dff_meta_if.sv | 12 +
 rtl/dff_meta_filter.sv | 44 ++++
 rtl/dff_meta.sv | 65 ++++++
 tb/tb_dff_meta.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/dff_meta_pkg.sv
// Shared helpers for the dff_meta synchronizer slice.
package dff_meta_pkg;

    // Filter counter width; a width of at least 1 keeps the bypass build legal.
    function automatic int cnt_width(input int filter_clks);
        return (filter_clks < 1) ? 1 : $clog2(filter_clks + 1);
    endfunction

endpackage

// File: rtl/dff_meta_if.sv
// Bundle of the synchronizer data signals, for benches and integrators that prefer a handle.
interface dff_meta_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;

    modport master (output d, input q, input rise, input fall);
    modport slave  (input d, output q, output rise, output fall);
endinterface

// File: rtl/dff_meta_filter.sv
// Single-bit stability filter: q follows s_out only after FILTER_CLKS consecutive differing cycles.
module dff_meta_filter
    import dff_meta_pkg::*;
#(
    parameter int   FILTER_CLKS = 1,
    parameter logic RESET_BIT   = 1'b0
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic s_out,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);
    localparam int            CW = cnt_width(FILTER_CLKS);
    localparam logic [CW-1:0] TC = CW'(FILTER_CLKS - 1);

    logic [CW-1:0] cnt;
    logic          next_q;

    always_comb begin
        next_q = q_o;
        if ((s_out != q_o) && (cnt == TC))
            next_q = s_out;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt    <= '0;
            q_o    <= RESET_BIT;
            rise_o <= 1'b0;
            fall_o <= 1'b0;
        end else begin
            q_o    <= next_q;
            rise_o <= next_q & ~q_o;
            fall_o <= ~next_q & q_o;
            // Any agreement, or a completed count, restarts the stability window.
            if ((s_out == q_o) || (cnt == TC))
                cnt <= '0;
            else
                cnt <= cnt + CW'(1);
        end
    end
endmodule

// File: rtl/dff_meta.sv
// Multi-stage metastability synchronizer with optional per-bit stability filter and edge pulses.
module dff_meta
    import dff_meta_pkg::*;
#(
    parameter int               WIDTH       = 1,
    parameter int               STAGES      = 2,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               FILTER_CLKS = 0
) (
    input  logic             reset_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic             clk_i,
    output logic [WIDTH-1:0] q_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o
);
    if ((STAGES < 2) || (STAGES > 4)) begin : g_bad_stages
        $error("dff_meta: STAGES must be within 2..4");
    end

    (* shreg_extract = "no", async_reg = "true", dont_retime = "true" *)
    logic [STAGES-1:0][WIDTH-1:0] sync;
    logic [WIDTH-1:0]             s_out;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sync <= {STAGES{RESET_VALUE}};
        end else begin
            sync[0] <= d_i;
            for (int n = 1; n < STAGES; n++)
                sync[n] <= sync[n-1];
        end
    end

    assign s_out = sync[STAGES-1];

    if (FILTER_CLKS == 0) begin : g_bypass
        assign q_o = s_out;

        // The stage feeding s_out is exactly the value q_o will show after the next edge.
        always_ff @(posedge clk_i or posedge reset_i) begin
            if (reset_i) begin
                rise_o <= '0;
                fall_o <= '0;
            end else begin
                rise_o <= sync[STAGES-2] & ~s_out;
                fall_o <= ~sync[STAGES-2] & s_out;
            end
        end
    end else begin : g_filter
        for (genvar b = 0; b < WIDTH; b++) begin : g_bit
            dff_meta_filter #(
                .FILTER_CLKS (FILTER_CLKS),
                .RESET_BIT   (RESET_VALUE[b])
            ) u_filter (
                .clk_i   (clk_i),
                .reset_i (reset_i),
                .s_out   (s_out[b]),
                .q_o     (q_o[b]),
                .rise_o  (rise_o[b]),
                .fall_o  (fall_o[b])
            );
        end
    end
endmodule

// File: tb/tb_dff_meta.sv
// Randomized bench for dff_meta: a filtered and an unfiltered instance against a history-based model.
module tb_dff_meta;
    localparam int         STG_A = 3;
    localparam int         FLT_A = 4;
    localparam logic [3:0] RV_A  = 4'b0101;
    localparam int         STG_B = 2;
    localparam int         FLT_B = 0;
    localparam logic [3:0] RV_B  = 4'b1010;

    logic clk;
    logic rst;
    logic [3:0] d;

    dff_meta_if #(.WIDTH(4)) ifa ();
    dff_meta_if #(.WIDTH(4)) ifb ();

    assign ifa.d = d;
    assign ifb.d = d;

    dff_meta #(.WIDTH(4), .STAGES(STG_A), .RESET_VALUE(RV_A), .FILTER_CLKS(FLT_A)) dut_a (
        .reset_i (rst),
        .d_i     (ifa.d),
        .clk_i   (clk),
        .q_o     (ifa.q),
        .rise_o  (ifa.rise),
        .fall_o  (ifa.fall)
    );

    dff_meta #(.WIDTH(4), .STAGES(STG_B), .RESET_VALUE(RV_B), .FILTER_CLKS(FLT_B)) dut_b (
        .reset_i (rst),
        .d_i     (ifb.d),
        .clk_i   (clk),
        .q_o     (ifb.q),
        .rise_o  (ifb.rise),
        .fall_o  (ifb.fall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: every d value sampled since reset release, plus the previous expected q.
    logic [3:0] dsamp[$];
    int         e;
    logic [3:0] qa_prev, qb_prev;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (edge %0d, t=%0t)", tag, obs, exp, e, $time);
        end
    endtask

    // s_out after edge j: the d sampled STAGES-1 edges earlier, or the reset value.
    function automatic logic [3:0] sout_at(input int j, input int stg, input logic [3:0] rv);
        if (j >= stg)
            return dsamp[j - stg];
        return rv;
    endfunction

    // A bit flips only when s_out disagreed with q before each of the last f edges.
    function automatic logic [3:0] model_q(input int ed, input int stg, input int f,
                                           input logic [3:0] rv, input logic [3:0] qprev);
        logic [3:0] r;
        logic       all_diff;
        logic [3:0] sv;
        if (f == 0)
            return sout_at(ed, stg, rv);
        r = qprev;
        if (ed >= f) begin
            for (int b = 0; b < 4; b++) begin
                all_diff = 1'b1;
                for (int j = ed - f; j < ed; j++) begin
                    sv = sout_at(j, stg, rv);
                    if (sv[b] == qprev[b])
                        all_diff = 1'b0;
                end
                if (all_diff)
                    r[b] = ~qprev[b];
            end
        end
        return r;
    endfunction

    task automatic check_reset_state();
        chk("a_rst_q",    ifa.q,    RV_A);
        chk("a_rst_rise", ifa.rise, 4'b0000);
        chk("a_rst_fall", ifa.fall, 4'b0000);
        chk("b_rst_q",    ifb.q,    RV_B);
        chk("b_rst_rise", ifb.rise, 4'b0000);
        chk("b_rst_fall", ifb.fall, 4'b0000);
    endtask

    // Assert reset mid-cycle, hold it across some edges, release mid-cycle.
    task automatic do_reset(input int hold);
        @(posedge clk);
        #3 rst = 1'b1;
        #1 check_reset_state();
        repeat (hold) @(posedge clk);
        #1 check_reset_state();
        #2 rst = 1'b0;
        dsamp.delete();
        e       = 0;
        qa_prev = RV_A;
        qb_prev = RV_B;
    endtask

    task automatic run(input logic [3:0] dn);
        logic [3:0] qa, qb;
        d = dn;
        @(posedge clk);
        dsamp.push_back(d);
        e++;
        qa = model_q(e, STG_A, FLT_A, RV_A, qa_prev);
        qb = model_q(e, STG_B, FLT_B, RV_B, qb_prev);
        #1;
        chk("a_q",    ifa.q,    qa);
        chk("a_rise", ifa.rise, qa & ~qa_prev);
        chk("a_fall", ifa.fall, ~qa & qa_prev);
        chk("b_q",    ifb.q,    qb);
        chk("b_rise", ifb.rise, qb & ~qb_prev);
        chk("b_fall", ifb.fall, ~qb & qb_prev);
        qa_prev = qa;
        qb_prev = qb;
    endtask

    initial begin
        logic [3:0] dr;
        rst = 1'b1;
        d   = 4'b0000;
        e   = 0;
        #2 check_reset_state();
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        dsamp.delete();
        qa_prev = RV_A;
        qb_prev = RV_B;

        // Inverse of B's reset value: every bit of B moves at once.
        repeat (8)  run(4'b0101);
        repeat (10) run(4'b1010);
        // Three-cycle glitch must not pass the filter.
        repeat (3)  run(4'b1111);
        repeat (8)  run(4'b1010);
        // Reset while A's filter count sits at 3 of 4, then the full window again.
        repeat (STG_A + 3) run(4'b0101);
        do_reset(1);
        repeat (12) run(4'b0101);

        dr = 4'b0101;
        for (int i = 0; i < 1500; i++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(5, 0) == 0)
                    dr[b] = ~dr[b];
            if ($urandom_range(199, 0) == 0)
                do_reset($urandom_range(2, 0));
            run(dr);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
